// File: rtl/thiele_graph_pkg.sv
// Shared definitions for the triadic_cascade colouring checker: graph size,
// colour codes, error codes, FSM states and the packed-colouring accessor.
package thiele_graph_pkg;

    localparam int NODES = 9;
    localparam int EDGES = 13;

    localparam logic [1:0] RED     = 2'd0;
    localparam logic [1:0] GREEN   = 2'd1;
    localparam logic [1:0] BLUE    = 2'd2;
    localparam logic [1:0] ILLEGAL = 2'd3;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
    localparam logic [2:0] ERR_ANCHOR   = 3'd2;
    localparam logic [2:0] ERR_CONFLICT = 3'd3;
    localparam logic [2:0] ERR_MU       = 3'd4;
    localparam logic [2:0] ERR_SOLVER   = 3'd5;

    localparam logic [3:0] LAST_NODE = 4'(NODES - 1);
    localparam logic [3:0] LAST_EDGE = 4'(EDGES - 1);
    localparam logic [3:0] NO_EDGE   = 4'hF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SCAN_NODES = 2'd1,
        SCAN_EDGES = 2'd2,
        REPORT     = 2'd3
    } state_t;

    // Node i occupies bits [2i+1:2i] of the packed colouring.
    function automatic logic [1:0] colour_of(input logic [17:0] colouring,
                                             input logic [3:0]  node);
        logic [17:0] shifted;
        shifted = colouring >> {node, 1'b0};
        return shifted[1:0];
    endfunction

endpackage

// File: rtl/thiele_edge_rom.sv
// Combinational edge table of the triadic_cascade graph: edge index -> (u, v).
// Shared with the solver's reasoning core; out-of-range indices give (0,0).
module thiele_edge_rom
    import thiele_graph_pkg::*;
(
    input  logic [3:0] edge_idx,
    output logic [3:0] node_u,
    output logic [3:0] node_v
);

    // Fixed edge ordering; the scan reports the lowest failing index from this order.
    always_comb begin
        node_u = 4'd0;
        node_v = 4'd0;
        case (edge_idx)
            4'd0:    begin node_u = 4'd0; node_v = 4'd1; end
            4'd1:    begin node_u = 4'd0; node_v = 4'd2; end
            4'd2:    begin node_u = 4'd1; node_v = 4'd2; end
            4'd3:    begin node_u = 4'd2; node_v = 4'd3; end
            4'd4:    begin node_u = 4'd2; node_v = 4'd4; end
            4'd5:    begin node_u = 4'd3; node_v = 4'd4; end
            4'd6:    begin node_u = 4'd3; node_v = 4'd5; end
            4'd7:    begin node_u = 4'd4; node_v = 4'd5; end
            4'd8:    begin node_u = 4'd5; node_v = 4'd6; end
            4'd9:    begin node_u = 4'd5; node_v = 4'd7; end
            4'd10:   begin node_u = 4'd6; node_v = 4'd7; end
            4'd11:   begin node_u = 4'd6; node_v = 4'd8; end
            4'd12:   begin node_u = 4'd7; node_v = 4'd8; end
            default: begin node_u = 4'd0; node_v = 4'd0; end
        endcase
    end

endmodule

// File: rtl/thiele_colouring_verifier.sv
// Re-checks a solver's 9-node colouring: node codes, anchors, every edge and
// the mu-cost budget, then holds a registered verdict until acknowledged.
module thiele_colouring_verifier
    import thiele_graph_pkg::*;
#(
    parameter logic [7:0] MU_BUDGET = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_success,
    input  logic [17:0] in_colouring,
    input  logic [7:0]  in_mu_cost,
    output logic        result_valid,
    input  logic        result_ack,
    output logic        verdict_ok,
    output logic [2:0]  err_code,
    output logic [3:0]  conflict_count,
    output logic [3:0]  first_bad_edge,
    output logic [7:0]  mu_margin
);

    state_t      state_r;
    state_t      next_state_s;

    logic [17:0] colouring_r;
    logic [7:0]  mu_cost_r;
    logic        success_r;
    logic [3:0]  idx_r;
    logic [3:0]  e_r;
    logic        illegal_r;
    logic        anchor_bad_r;
    logic [3:0]  cc_r;
    logic [3:0]  fbe_r;

    logic [1:0]  node_code_s;
    logic        illegal_next_s;
    logic        anchor_hit_s;
    logic [3:0]  edge_u_s;
    logic [3:0]  edge_v_s;
    logic        conflict_s;
    logic [2:0]  err_s;
    logic [7:0]  margin_s;

    thiele_edge_rom u_edge_rom (
        .edge_idx (e_r),
        .node_u   (edge_u_s),
        .node_v   (edge_v_s)
    );

    assign in_ready = (state_r == IDLE);

    // Per-cycle node and edge evaluation on the captured colouring.
    always_comb begin
        node_code_s    = colour_of(colouring_r, idx_r);
        illegal_next_s = illegal_r | (node_code_s == ILLEGAL);
        anchor_hit_s   = ((idx_r == 4'd0) && (node_code_s != RED)) ||
                         ((idx_r == 4'd1) && (node_code_s != GREEN));
        conflict_s     = (colour_of(colouring_r, edge_u_s) == colour_of(colouring_r, edge_v_s));
    end

    // Verdict priority: solver failure, illegal code, anchor, edge conflict, budget.
    always_comb begin
        err_s = ERR_NONE;
        if (!success_r) begin
            err_s = ERR_SOLVER;
        end else if (illegal_r) begin
            err_s = ERR_ILLEGAL;
        end else if (anchor_bad_r) begin
            err_s = ERR_ANCHOR;
        end else if (cc_r != 4'd0) begin
            err_s = ERR_CONFLICT;
        end else if (mu_cost_r > MU_BUDGET) begin
            err_s = ERR_MU;
        end else begin
            err_s = ERR_NONE;
        end
        if (mu_cost_r >= MU_BUDGET) begin
            margin_s = 8'd0;
        end else begin
            margin_s = MU_BUDGET - mu_cost_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; REPORT waits for its own registered result_valid before honouring ack.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = in_success ? SCAN_NODES : REPORT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SCAN_NODES: begin
                if (idx_r == LAST_NODE) begin
                    next_state_s = illegal_next_s ? REPORT : SCAN_EDGES;
                end else begin
                    next_state_s = SCAN_NODES;
                end
            end
            SCAN_EDGES: begin
                if (e_r == LAST_EDGE) begin
                    next_state_s = REPORT;
                end else begin
                    next_state_s = SCAN_EDGES;
                end
            end
            REPORT: begin
                if (result_valid && result_ack) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REPORT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Capture, scan accumulators and the frozen verdict registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colouring_r    <= 18'd0;
            mu_cost_r      <= 8'd0;
            success_r      <= 1'b0;
            idx_r          <= 4'd0;
            e_r            <= 4'd0;
            illegal_r      <= 1'b0;
            anchor_bad_r   <= 1'b0;
            cc_r           <= 4'd0;
            fbe_r          <= NO_EDGE;
            result_valid   <= 1'b0;
            verdict_ok     <= 1'b0;
            err_code       <= ERR_NONE;
            conflict_count <= 4'd0;
            first_bad_edge <= NO_EDGE;
            mu_margin      <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        colouring_r  <= in_colouring;
                        mu_cost_r    <= in_mu_cost;
                        success_r    <= in_success;
                        idx_r        <= 4'd0;
                        e_r          <= 4'd0;
                        illegal_r    <= 1'b0;
                        anchor_bad_r <= 1'b0;
                        cc_r         <= 4'd0;
                        fbe_r        <= NO_EDGE;
                    end
                end
                SCAN_NODES: begin
                    illegal_r    <= illegal_next_s;
                    anchor_bad_r <= anchor_bad_r | anchor_hit_s;
                    idx_r        <= idx_r + 4'd1;
                end
                SCAN_EDGES: begin
                    if (conflict_s) begin
                        cc_r <= cc_r + 4'd1;
                        if (fbe_r == NO_EDGE) begin
                            fbe_r <= e_r;
                        end
                    end
                    e_r <= e_r + 4'd1;
                end
                REPORT: begin
                    if (!result_valid) begin
                        result_valid   <= 1'b1;
                        verdict_ok     <= (err_s == ERR_NONE);
                        err_code       <= err_s;
                        conflict_count <= cc_r;
                        first_bad_edge <= fbe_r;
                        mu_margin      <= margin_s;
                    end else if (result_ack) begin
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
